// File: rtl/match_scorer.sv
// First-to-WIN_TARGET match scorer: accepts judged rounds, keeps per-player scores and the
// round count, and ends the match with a champion or a drawn match at MAX_ROUNDS.
module match_scorer #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               round_valid,
    output logic               round_ready,
    input  logic               winA,
    input  logic               winB,
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               busy,
    output logic               match_done,
    output logic               champA,
    output logic               champB,
    output logic               draw_match,
    output logic               judge_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(WIN_TARGET);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               champ_a_q, champ_a_d;
    logic               champ_b_q, champ_b_d;
    logic               draw_q, draw_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

    // Counters hold at full scale rather than wrap; the match ends long before that.
    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [ROUND_W-1:0] sat_inc_round(input logic [ROUND_W-1:0] v);
        return (v == {ROUND_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // ready_q is high exactly while in PLAY, so it doubles as the accept qualifier.
    assign accept = round_valid & ready_q;

    always_comb begin
        state_d   = state_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        round_d   = round_q;
        champ_a_d = champ_a_q;
        champ_b_d = champ_b_q;
        draw_d    = draw_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_PLAY;
                    score_a_d = '0;
                    score_b_d = '0;
                    round_d   = '0;
                    champ_a_d = 1'b0;
                    champ_b_d = 1'b0;
                    draw_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            S_PLAY: begin
                if (accept) begin
                    round_d = sat_inc_round(round_q);
                    if (winA && !winB) begin
                        score_a_d = sat_inc_score(score_a_q);
                    end
                    if (winB && !winA) begin
                        score_b_d = sat_inc_score(score_b_q);
                    end
                    if (winA && winB) begin
                        err_d = 1'b1;
                    end
                    // Decide on the post-update values so the result lands on the accepting edge.
                    if (score_a_d == WIN_SCORE) begin
                        champ_a_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (score_b_d == WIN_SCORE) begin
                        champ_b_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (round_d == LAST_ROUND) begin
                        draw_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_PLAY);
        busy_d  = (state_d == S_PLAY);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            score_a_q <= '0;
            score_b_q <= '0;
            round_q   <= '0;
            champ_a_q <= 1'b0;
            champ_b_q <= 1'b0;
            draw_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            round_q   <= round_d;
            champ_a_q <= champ_a_d;
            champ_b_q <= champ_b_d;
            draw_q    <= draw_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign round_ready = ready_q;
    assign scoreA      = score_a_q;
    assign scoreB      = score_b_q;
    assign round_cnt   = round_q;
    assign busy        = busy_q;
    assign match_done  = done_q;
    assign champA      = champ_a_q;
    assign champB      = champ_b_q;
    assign draw_match  = draw_q;
    assign judge_err   = err_q;

endmodule

// File: tb/tb_match_scorer.sv
// Directed bench for match_scorer: a behavioural model pushes expected outputs per cycle,
// and they are popped and compared one cycle later against the DUT.
module tb_match_scorer;

    localparam int WIN_TARGET = 3;
    localparam int MAX_ROUNDS = 9;
    localparam int SCORE_W    = 4;
    localparam int ROUND_W    = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               round_valid = 1'b0;
    logic               round_ready;
    logic               winA = 1'b0;
    logic               winB = 1'b0;
    logic [SCORE_W-1:0] scoreA;
    logic [SCORE_W-1:0] scoreB;
    logic [ROUND_W-1:0] round_cnt;
    logic               busy;
    logic               match_done;
    logic               champA;
    logic               champB;
    logic               draw_match;
    logic               judge_err;

    match_scorer #(
        .WIN_TARGET(WIN_TARGET),
        .MAX_ROUNDS(MAX_ROUNDS),
        .SCORE_W   (SCORE_W),
        .ROUND_W   (ROUND_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .round_valid(round_valid),
        .round_ready(round_ready),
        .winA       (winA),
        .winB       (winB),
        .scoreA     (scoreA),
        .scoreB     (scoreB),
        .round_cnt  (round_cnt),
        .busy       (busy),
        .match_done (match_done),
        .champA     (champA),
        .champB     (champB),
        .draw_match (draw_match),
        .judge_err  (judge_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sa;
        int sb;
        int rc;
        int ready;
        int busy;
        int done;
        int ca;
        int cb;
        int dr;
        int err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: 0 idle, 1 play, 2 done
    int m_state, m_sa, m_sb, m_rc, m_ca, m_cb, m_dr, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sa = 0; m_sb = 0; m_rc = 0; m_ca = 0; m_cb = 0; m_dr = 0; m_err = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.sa    = m_sa;
        e.sb    = m_sb;
        e.rc    = m_rc;
        e.ready = (m_state == 1) ? 1 : 0;
        e.busy  = (m_state == 1) ? 1 : 0;
        e.done  = (m_state == 2) ? 1 : 0;
        e.ca    = m_ca;
        e.cb    = m_cb;
        e.dr    = m_dr;
        e.err   = m_err;
        sb_q.push_back(e);
    endtask

    task automatic model_step(input bit st, input bit v, input bit a, input bit b);
        if (m_state == 0 || m_state == 2) begin
            if (st) begin
                model_clear();
                m_state = 1;
            end
        end else if (v) begin
            m_rc++;
            if (a && !b) m_sa++;
            if (b && !a) m_sb++;
            if (a && b)  m_err = 1;
            if (m_sa == WIN_TARGET) begin
                m_ca = 1; m_state = 2;
            end else if (m_sb == WIN_TARGET) begin
                m_cb = 1; m_state = 2;
            end else if (m_rc == MAX_ROUNDS) begin
                m_dr = 1; m_state = 2;
            end
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_scoreA"},      32'(scoreA),      e.sa);
        chk({tag, "_scoreB"},      32'(scoreB),      e.sb);
        chk({tag, "_round_cnt"},   32'(round_cnt),   e.rc);
        chk({tag, "_round_ready"}, 32'(round_ready), e.ready);
        chk({tag, "_busy"},        32'(busy),        e.busy);
        chk({tag, "_match_done"},  32'(match_done),  e.done);
        chk({tag, "_champA"},      32'(champA),      e.ca);
        chk({tag, "_champB"},      32'(champB),      e.cb);
        chk({tag, "_draw_match"},  32'(draw_match),  e.dr);
        chk({tag, "_judge_err"},   32'(judge_err),   e.err);
    endtask

    // One clock with the given inputs; inputs change #1 after an edge, outputs sampled #1 after the next.
    task automatic cyc(input string tag, input bit st, input bit v, input bit a, input bit b);
        start = st; round_valid = v; winA = a; winB = b;
        model_step(st, v, a, b);
        push_expected();
        @(posedge clk); #1;
        start = 1'b0; round_valid = 1'b0; winA = 1'b0; winB = 1'b0;
        compare_out(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        start = 1'b0; round_valid = 1'b0; winA = 1'b0; winB = 1'b0;
        m_state = 0;
        model_clear();
        push_expected();
        @(posedge clk); #1;
        rst_n = 1'b1;
        compare_out(tag);
    endtask

    initial begin
        m_state = 0;
        model_clear();
        @(posedge clk); #1;

        // 1: reset, start, A,A,A
        do_reset("t1_reset");
        cyc("t1_start", 1, 0, 0, 0);
        cyc("t1_r1", 0, 1, 1, 0);
        cyc("t1_r2", 0, 1, 1, 0);
        cyc("t1_r3", 0, 1, 1, 0);
        chk("t1_final_scoreA", 32'(scoreA), 3);
        chk("t1_final_rc", 32'(round_cnt), 3);
        chk("t1_final_champA", 32'(champA), 1);
        cyc("t1_hold", 0, 0, 0, 0);

        // 2: B reaches 3 on the 7th round with A at 2
        cyc("t2_start", 1, 0, 0, 0);
        cyc("t2_r1", 0, 1, 1, 0);
        cyc("t2_r2", 0, 1, 0, 1);
        cyc("t2_r3", 0, 1, 0, 0);
        cyc("t2_r4", 0, 1, 0, 1);
        cyc("t2_r5", 0, 1, 1, 0);
        cyc("t2_r6", 0, 1, 0, 0);
        chk("t2_not_done_r6", 32'(match_done), 0);
        cyc("t2_r7", 0, 1, 0, 1);
        chk("t2_final_scoreB", 32'(scoreB), 3);
        chk("t2_final_scoreA", 32'(scoreA), 2);
        chk("t2_final_rc", 32'(round_cnt), 7);
        chk("t2_final_champB", 32'(champB), 1);

        // 5a: round_valid pulses in DONE are ignored
        cyc("t5_done_pulse1", 0, 1, 1, 0);
        cyc("t5_done_pulse2", 0, 1, 0, 1);

        // 3: nine draws
        cyc("t3_start", 1, 0, 0, 0);
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            cyc($sformatf("t3_r%0d", i + 1), 0, 1, 0, 0);
        end
        chk("t3_final_rc", 32'(round_cnt), 9);
        chk("t3_final_draw", 32'(draw_match), 1);
        chk("t3_final_scores", 32'({scoreA, scoreB}), 0);

        // 4: double-win round, start ignored mid-match, then clear on restart
        cyc("t4_start", 1, 0, 0, 0);
        cyc("t4_both", 0, 1, 1, 1);
        chk("t4_err", 32'(judge_err), 1);
        chk("t4_rc", 32'(round_cnt), 1);
        chk("t4_scores", 32'({scoreA, scoreB}), 0);
        cyc("t5_start_in_play", 1, 1, 1, 0);
        cyc("t4_r3", 0, 0, 0, 0);
        cyc("t4_r3b", 0, 1, 1, 0);
        cyc("t4_r4", 0, 1, 1, 0);
        chk("t4_err_held", 32'(judge_err), 1);
        cyc("t4_restart", 1, 0, 0, 0);
        chk("t4_err_cleared", 32'(judge_err), 0);

        // 6: reset mid-match at scoreA=2, IDLE pulses ignored, then a full match
        cyc("t6_r1", 0, 1, 1, 0);
        cyc("t6_r2", 0, 1, 1, 0);
        chk("t6_pre_scoreA", 32'(scoreA), 2);
        do_reset("t6_reset");
        cyc("t5_idle_pulse1", 0, 1, 1, 0);
        cyc("t5_idle_pulse2", 0, 1, 0, 1);
        cyc("t6_start", 1, 0, 0, 0);
        cyc("t6_m1", 0, 1, 0, 1);
        cyc("t6_m2", 0, 1, 1, 0);
        cyc("t6_m3", 0, 1, 0, 1);
        cyc("t6_m4", 0, 1, 0, 1);
        chk("t6_final_champB", 32'(champB), 1);
        cyc("t6_hold", 0, 0, 0, 0);

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
